// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshaking.
// Stage 1 registers the operand beat; stage 2 computes the result, the
// {N,V,C,Z} flags and the multiply-accumulate value and holds them until
// downstream accepts. The accumulator lives entirely in stage 2, so
// back-to-back MACs see each other's results without any forwarding.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH + 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_flags,
   output logic [ACC_W-1:0] out_acc
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NOT  = 4'd2,
      OP_NAND = 4'd3,
      OP_NOR  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_ADDS = 4'd8,
      OP_SUBS = 4'd9,
      OP_SHL  = 4'd10,
      OP_SHR  = 4'd11,
      OP_SRA  = 4'd12,
      OP_MUL  = 4'd13,
      OP_MAC  = 4'd14,
      OP_ACLR = 4'd15
   } op_e;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   // Stage 1 state
   logic             s1_valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   op_e              op_q;

   // Stage 2 state; the accumulator register doubles as out_acc because
   // every beat reports the accumulator value left behind by its own op.
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [3:0]       out_flags_q;
   logic [ACC_W-1:0] acc_q;

   // Handshake
   logic adv2;
   logic accept;

   assign adv2      = !out_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || adv2;
   assign accept    = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_flags = out_flags_q;
   assign out_acc   = acc_q;

   // Datapath intermediates
   logic [WIDTH:0]          add_ext;
   logic [WIDTH:0]          sub_ext;
   logic                    add_ovf;
   logic                    sub_ovf;
   logic [WIDTH-1:0]        sat_val;
   logic                    shift_in_range;
   logic [WIDTH:0]          shl_ext;
   logic [WIDTH:0]          shr_ext;
   logic signed [WIDTH:0]   sra_src;
   logic [WIDTH:0]          sra_ext;
   logic [WIDTH-1:0]        mul_lo;
   logic signed [2*WIDTH-1:0] a_sx;
   logic signed [2*WIDTH-1:0] b_sx;
   logic signed [2*WIDTH-1:0] mac_prod;
   logic [ACC_W-1:0]        mac_ext;
   logic [ACC_W-1:0]        acc_sum;
   logic [ACC_W-WIDTH:0]    acc_upper;
   logic                    acc_fits;
   logic [WIDTH-1:0]        mac_res;

   // Shared arithmetic, shift and multiply terms feeding the op select
   always_comb begin
      add_ext = {1'b0, a_q} + {1'b0, b_q};
      sub_ext = {1'b0, a_q} - {1'b0, b_q};
      // Signed overflow: same-sign add or opposite-sign subtract whose
      // result sign differs from a; the clamp direction follows a's sign.
      add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
      sat_val = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;

      // One guard bit beside the operand catches the last bit shifted out;
      // oversized amounts naturally drain to zero (or to the sign for SRA).
      shift_in_range = (b_q <= WIDTH_V);
      shl_ext = {1'b0, a_q} << b_q;
      shr_ext = {a_q, 1'b0} >> b_q;
      sra_src = {a_q, 1'b0};
      sra_ext = sra_src >>> b_q;

      mul_lo = a_q * b_q;

      a_sx      = (2*WIDTH)'($signed(a_q));
      b_sx      = (2*WIDTH)'($signed(b_q));
      mac_prod  = a_sx * b_sx;
      mac_ext   = ACC_W'(mac_prod);
      acc_sum   = acc_q + mac_ext;
      // The sum fits in signed WIDTH when every bit above the result sign
      // agrees with it.
      acc_upper = acc_sum[ACC_W-1:WIDTH-1];
      acc_fits  = (&acc_upper) || !(|acc_upper);
      mac_res   = acc_fits ? acc_sum[WIDTH-1:0] : (acc_sum[ACC_W-1] ? SAT_MIN : SAT_MAX);
   end

   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             v_d;
   logic [ACC_W-1:0] acc_d;
   logic [3:0]       flags_d;

   // Opcode select for result, carry/overflow and next accumulator
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // opcode path leaves one unassigned and infers a latch.
      res_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
      acc_d = acc_q;
      case (op_q)
         OP_ADD: begin
            res_d = add_ext[WIDTH-1:0];
            c_d   = add_ext[WIDTH];
            v_d   = add_ovf;
         end
         OP_SUB: begin
            res_d = sub_ext[WIDTH-1:0];
            c_d   = sub_ext[WIDTH];
            v_d   = sub_ovf;
         end
         OP_NOT:  res_d = ~a_q;
         OP_NAND: res_d = ~(a_q & b_q);
         OP_NOR:  res_d = ~(a_q | b_q);
         OP_AND:  res_d = a_q & b_q;
         OP_OR:   res_d = a_q | b_q;
         OP_XOR:  res_d = a_q ^ b_q;
         OP_ADDS: begin
            res_d = add_ovf ? sat_val : add_ext[WIDTH-1:0];
            c_d   = add_ext[WIDTH];
            v_d   = add_ovf;
         end
         OP_SUBS: begin
            res_d = sub_ovf ? sat_val : sub_ext[WIDTH-1:0];
            c_d   = sub_ext[WIDTH];
            v_d   = sub_ovf;
         end
         OP_SHL: begin
            res_d = shl_ext[WIDTH-1:0];
            c_d   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res_d = shr_ext[WIDTH:1];
            c_d   = shr_ext[0];
         end
         OP_SRA: begin
            res_d = sra_ext[WIDTH:1];
            c_d   = shift_in_range ? sra_ext[0] : 1'b0;
         end
         OP_MUL:  res_d = mul_lo;
         OP_MAC: begin
            res_d = mac_res;
            v_d   = !acc_fits;
            acc_d = acc_sum;
         end
         OP_ACLR: acc_d = '0;
         default: ;
      endcase
      flags_d = {res_d[WIDTH-1], v_d, c_d, (res_d == '0)};
   end

   // Stage 1: capture an accepted beat, or empty when it moves on
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of block ordering.
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         a_q        <= in_a;
         b_q        <= in_b;
         op_q       <= op_e'(in_op);
      end else if (adv2) begin
         s1_valid_q <= 1'b0;
      end
   end

   // Stage 2: register result and accumulator whenever the output slot frees
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
         acc_q       <= '0;
      end else if (adv2) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q  <= res_d;
            out_flags_q <= flags_d;
            acc_q       <= acc_d;
         end
      end
   end

endmodule
